// File: rtl/protocol_pkg.sv
// rtl/protocol_pkg.sv - shared state, error-code and marker definitions for the sensor request/response protocol
package protocol_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_CMD  = 3'd2,
        ST_CHK  = 3'd3,
        ST_FOOT = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_BAD_FOOTER = 3'd1;
    localparam logic [2:0] ERR_BAD_ADDR   = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW   = 3'd4;
    localparam logic [2:0] ERR_BAD_CHK    = 3'd5;

    localparam logic [7:0] DEFAULT_SYNC_BYTE   = 8'hFF;
    localparam logic [7:0] DEFAULT_FOOTER_BYTE = 8'h7F;

endpackage

// File: rtl/protocol_timeout_cnt.sv
// rtl/protocol_timeout_cnt.sv - clear/enable inactivity counter that flags expiry after TIMEOUT_CYC idle cycles
module protocol_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // A clear in the expiry cycle (an accepted beat) suppresses the expiry.
    assign expire = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/protocol_req_rx.sv
// rtl/protocol_req_rx.sv - sensor request packet receiver; PROTOCOL_REQ_CHECKSUM_EN adds the CHK byte
module protocol_req_rx
    import protocol_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE   = DATA_W'(DEFAULT_SYNC_BYTE),
    parameter logic [DATA_W-1:0] FOOTER_BYTE = DATA_W'(DEFAULT_FOOTER_BYTE),
    parameter int                NUM_SENSORS = 32,
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_cmd,
    output logic              err,
    output logic [2:0]        err_code
);

    localparam logic [DATA_W:0] ADDR_LIMIT = (DATA_W + 1)'(NUM_SENSORS);

    state_t            state;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] cmd_q;
    logic              chk_ok;
    logic              expire;
    logic              addr_bad;
    logic              hold_blocked;

    assign addr_bad     = {1'b0, addr_q} >= ADDR_LIMIT;
    assign hold_blocked = out_valid && !out_ready;

    protocol_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   ((state == ST_IDLE) || in_valid),
        .en    (state != ST_IDLE),
        .expire(expire)
    );

`ifdef PROTOCOL_REQ_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_ok <= 1'b1;
        end else if (in_valid && state == ST_CHK) begin
            chk_ok <= (in_data == (addr_q ^ cmd_q));
        end
    end
`else
    assign chk_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            cmd_q     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_cmd   <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (expire) begin
                state    <= ST_IDLE;
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
            end else if (in_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            state <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        addr_q <= in_data;
                        state  <= ST_CMD;
                    end
                    ST_CMD: begin
                        cmd_q <= in_data;
`ifdef PROTOCOL_REQ_CHECKSUM_EN
                        state <= ST_CHK;
`else
                        state <= ST_FOOT;
`endif
                    end
`ifdef PROTOCOL_REQ_CHECKSUM_EN
                    ST_CHK: begin
                        state <= ST_FOOT;
                    end
`endif
                    ST_FOOT: begin
                        state <= ST_IDLE;
                        if (in_data != FOOTER_BYTE) begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_FOOTER;
                        end else if (!chk_ok) begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_CHK;
                        end else if (addr_bad) begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_ADDR;
                        end else if (hold_blocked) begin
                            err      <= 1'b1;
                            err_code <= ERR_OVERFLOW;
                        end else begin
                            // Overrides the drain clear above when both happen together.
                            out_valid <= 1'b1;
                            out_addr  <= addr_q;
                            out_cmd   <= cmd_q;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
